uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver that generalises the single-byte receiver. It adds optional parity, 3-sample majority voting, a false-start filter, and per-byte framing/parity error flags. Received bytes go into a show-ahead FIFO of configurable depth. RTS flow control is driven from FIFO fill level, so the CPU-side consumer can tolerate bursts.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BIT_RATE, 9600, line bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide, must be >= 8)
PAYLOAD_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2
RTS_THRESHOLD, FIFO_DEPTH-1, fill level at or above which RTS deasserts (1..FIFO_DEPTH)

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
uart_rxd  in  1  serial receive line, asynchronous, idle high
uart_rts  out  1  request-to-send, active low (0 = ready to accept)
rx_read  in  1  pop head FIFO entry this cycle
rx_valid  out  1  FIFO non-empty
rx_data  out  PAYLOAD_BITS  head entry data, LSB = first bit received
rx_frame_err  out  1  head entry had a low first stop bit
rx_parity_err  out  1  head entry parity mismatch; always 0 when PARITY = 0
rx_overrun  out  1  sticky: a completed frame was dropped because the FIFO was full
clear_overrun  in  1  clears rx_overrun
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of valid entries

Behaviour:
- Reset values (async, active-low): uart_rts = 1, rx_valid = 0, rx_data = 0, both error outputs 0, rx_overrun = 0, fifo_level = 0, FSM in IDLE, synchroniser flops = 1.
- Input path: 2-flop synchroniser on uart_rxd; the FSM uses only the synchronised value (rxs).
- Bit counter:
  - Counts 0..CYCLES_PER_BIT-1, then wraps to 0 and advances the bit.
  - Held at 0 in IDLE and WAIT_HIGH.
  - MID = CYCLES_PER_BIT/2.
- Bit sampling: rxs is sampled at counts MID-1, MID and MID+1; the bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rxs = 0 -> START, counter starts at 0.
  - START: majority at MID+1 = 1 -> false start, back to IDLE, nothing pushed. Otherwise go to DATA at the counter wrap.
  - DATA: PAYLOAD_BITS bits, LSB first, shifted in at each majority decision. At the wrap after the last bit -> PARITY if PARITY != 0, else STOP.
  - PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd. A mismatch sets the entry's parity_err.
  - STOP: the first stop bit's majority = 0 sets frame_err. With STOP_BITS = 2, the second stop bit is also timed; frame_err is set if either stop bit is 0.
    - At MID+1 of the final stop bit, push {frame_err, parity_err, data} into the FIFO.
    - Then go to IDLE if frame_err = 0, else to WAIT_HIGH.
    - Exiting at mid-bit allows a back-to-back start edge to be detected.
  - WAIT_HIGH: stay until rxs = 1, then IDLE. This absorbs break conditions; a break yields exactly one entry with frame_err = 1 and data = 0.
- FIFO (show-ahead):
  - rx_valid, rx_data and the error outputs reflect the head entry combinationally from storage.
  - Push takes effect at the clock edge; rx_valid rises the cycle after the push edge (2 cycles after the final stop sample).
  - rx_read with rx_valid = 1 pops at the edge; rx_read while empty is ignored.
  - Push and pop in the same cycle: both occur and the level is unchanged. This includes the full case, which is not an overrun.
  - Push while full without a pop: the frame is dropped, the FIFO is unchanged, and rx_overrun <= 1.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is 0..FIFO_DEPTH.
- rx_overrun: cleared by clear_overrun. If clear and a new overrun occur in the same cycle, the set wins.
- uart_rts is registered: uart_rts <= (fifo_level >= RTS_THRESHOLD). It is updated every cycle, independent of FSM state, so it goes 0 on the first cycle after reset release.
- Mid-frame reset: everything returns to reset values immediately. A partial frame is discarded, the FIFO is emptied and rx_overrun is cleared.

Test Plan:
(Bench settings: CLK_HZ = 1_000_000, BIT_RATE = 100_000, so CYCLES_PER_BIT = 10, plus the listed overrides.)
- PARITY = 0: send 0xA5 with a valid stop bit.
  -> rx_valid = 1 two cycles after the final stop sample, rx_data = 0xA5, both error flags 0, fifo_level = 1. rx_read for one cycle -> rx_valid = 0.
- PARITY = 1: send 0x03 with parity bit 1.
  -> rx_parity_err = 1. Send 0x03 with parity bit 0 -> rx_parity_err = 0. Repeat with PARITY = 2 and expect the inverse.
- 3-cycle low glitch on an idle line.
  -> no push, fifo_level = 0.
  A single-cycle high spike at the MID sample of a 0 data bit -> that bit is still received as 0.
- Hold rxd low for 20 bit times, then release.
  -> exactly one entry {frame_err = 1, data = 0x00}; next frame 0x55 is received correctly.
- FIFO_DEPTH = 4, RTS_THRESHOLD = 3: send 5 frames 0x01..0x05 without reading.
  -> uart_rts = 1 from the cycle after the 3rd push; rx_overrun = 1 after the 5th; popped data is 0x01..0x04 in order.
  Pulse clear_overrun -> rx_overrun = 0; rx_read held during the push of a frame into a full FIFO -> no overrun, level stays 4.
- Assert resetn low during the DATA bits of a frame with 2 entries queued.
  -> immediately fifo_level = 0, rx_valid = 0, uart_rts = 1. After release, the next full frame 0x7E is received intact.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote sampling, optional parity, false-start filtering
// and per-byte error flags, feeding a show-ahead FIFO that drives RTS flow control.
module uart_rx_fifo #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BIT_RATE      = 9600,
    parameter int PAYLOAD_BITS  = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int RTS_THRESHOLD = FIFO_DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          uart_rxd,
    output logic                          uart_rts,
    input  logic                          rx_read,
    output logic                          rx_valid,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_overrun,
    input  logic                          clear_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int EW  = PAYLOAD_BITS + 2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_S0    = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(CPB / 2);
    localparam logic [CW-1:0] CNT_S2    = CW'(CPB / 2 + 1);
    localparam logic [3:0]    LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] RTS_LVL   = LW'(RTS_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic exp_parity(input logic [PAYLOAD_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    logic                    meta_q;
    logic                    rxs_q;
    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [3:0]              bit_q;
    logic                    samp0_q;
    logic                    samp1_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic                    ferr_q;
    logic                    perr_q;
    logic                    push_q;
    logic [EW-1:0]           push_entry_q;

    logic [EW-1:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [LW-1:0]           level_q;
    logic [LW-1:0]           level_d;
    logic                    ovr_q;
    logic                    rts_q;

    logic                    maj_s;
    logic                    at_s2_s;
    logic                    wrap_s;
    logic [CW-1:0]           cnt_inc_s;
    logic                    stop_ferr_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    wr_s;
    logic                    drop_s;
    logic [EW-1:0]           head_s;

    // Two-flop synchroniser for the asynchronous receive line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= uart_rxd;
            rxs_q  <= meta_q;
        end
    end

    assign maj_s       = maj3(samp0_q, samp1_q, rxs_q);
    assign at_s2_s     = (cnt_q == CNT_S2);
    assign wrap_s      = (cnt_q == CNT_LAST);
    assign cnt_inc_s   = wrap_s ? '0 : cnt_q + CW'(1);
    assign stop_ferr_s = ferr_q | ~maj_s;

    // Frame FSM: the bit decision is taken at the third sample, when rxs_q is the last vote.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 4'd0;
            samp0_q      <= 1'b1;
            samp1_q      <= 1'b1;
            shift_q      <= '0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (cnt_q == CNT_S0) begin
                samp0_q <= rxs_q;
            end
            if (cnt_q == CNT_S1) begin
                samp1_q <= rxs_q;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rxs_q) begin
                        state_q <= S_START;
                        bit_q   <= 4'd0;
                        ferr_q  <= 1'b0;
                        perr_q  <= 1'b0;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_inc_s;
                    if (at_s2_s && maj_s) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (wrap_s) begin
                        state_q <= S_DATA;
                        bit_q   <= 4'd0;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_inc_s;
                    if (at_s2_s) begin
                        shift_q <= {maj_s, shift_q[PAYLOAD_BITS-1:1]};
                    end
                    if (wrap_s) begin
                        if (bit_q == LAST_DATA) begin
                            bit_q   <= 4'd0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_q <= cnt_inc_s;
                    if (at_s2_s) begin
                        perr_q <= (maj_s != exp_parity(shift_q));
                    end
                    if (wrap_s) begin
                        state_q <= S_STOP;
                        bit_q   <= 4'd0;
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_inc_s;
                    if (at_s2_s) begin
                        ferr_q <= stop_ferr_s;
                        // Leaving at mid-bit lets a back-to-back start edge be caught.
                        if (bit_q == LAST_STOP) begin
                            push_q       <= 1'b1;
                            push_entry_q <= {stop_ferr_s, perr_q, shift_q};
                            cnt_q        <= '0;
                            state_q      <= stop_ferr_s ? S_WAIT_HIGH : S_IDLE;
                        end
                    end else if (wrap_s) begin
                        bit_q <= bit_q + 4'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // FIFO control: a push into a full FIFO succeeds only when a pop frees a slot that cycle.
    always_comb begin
        pop_s   = rx_read & (level_q != '0);
        full_s  = (level_q == FULL_LVL);
        wr_s    = push_q & (~full_s | pop_s);
        drop_s  = push_q & full_s & ~pop_s;
        level_d = level_q;
        case ({wr_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers, level, sticky overrun and registered RTS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
            rts_q    <= 1'b1;
        end else begin
            level_q <= level_d;
            rts_q   <= (level_q >= RTS_LVL);
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop_s) begin
                ovr_q <= 1'b1;
            end else if (clear_overrun) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= push_entry_q;
        end
    end

    assign head_s = mem_q[rd_ptr_q];

    // Show-ahead head view, forced to zero while empty.
    always_comb begin
        if (level_q != '0) begin
            rx_valid      = 1'b1;
            rx_data       = head_s[PAYLOAD_BITS-1:0];
            rx_frame_err  = head_s[EW-1];
            rx_parity_err = head_s[EW-2];
        end else begin
            rx_valid      = 1'b0;
            rx_data       = '0;
            rx_frame_err  = 1'b0;
            rx_parity_err = 1'b0;
        end
    end

    assign rx_overrun = ovr_q;
    assign uart_rts   = rts_q;
    assign fifo_level = level_q;

endmodule
